// File: rtl/i2c_target_regs.sv
// I2C target exposing a 4 x 8-bit register file, with a CPU local-bus port for preload and readback.
// Latency: SCL/SDA pass through a 2-flop sync plus history flop (3 sys clocks); d_out is valid 1 cycle after rd.
// Backpressure: none; SCL is never stretched, and the local bus always accepts accesses.
`timescale 1ns/1ps
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] d_in,
  output logic [7:0]  d_out
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT
  } state_t;

  state_t      state, state_nxt;
  logic        scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic [7:0]  regs [4];
  logic [6:0]  shreg;      // low 7 bits of the byte in flight (rx history or tx remainder)
  logic [2:0]  cnt;
  logic        byte_done;  // byte complete and ACK pending; in RACK: controller ACKed
  logic        rw;
  logic [1:0]  ptr;
  logic        wr_done, busy;
  logic        oe_nxt;
  logic        unused_hi;

  wire scl_rise = scl_s2 & ~scl_h;
  wire scl_fall = ~scl_s2 & scl_h;
  wire start    = scl_s2 & scl_h & sda_h & ~sda_s2;
  wire stop     = scl_s2 & scl_h & ~sda_h & sda_s2;
  wire [7:0] rx_byte = {shreg, sda_s2};
  wire match    = (rx_byte[7:1] == TARGET_ADDR);
  wire last_rise = scl_rise && (cnt == 3'd7);
  wire i2c_we   = (state == WDATA) && last_rise && !start && !stop;

  assign unused_hi = ^d_in[15:8];

  // Synchronize the bus lines and keep one history sample for edge detection
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl_i, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda_i, sda_s1, sda_s2};
    end
  end

  // State register
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next state: START/STOP override everything, otherwise advance on SCL edges
  always_comb begin
    state_nxt = state;
    if (start)     state_nxt = ADDR;
    else if (stop) state_nxt = IDLE;
    else begin
      case (state)
        ADDR: begin
          if (last_rise && !match)          state_nxt = IDLE;
          else if (scl_fall && byte_done)   state_nxt = ADDR_ACK;
        end
        ADDR_ACK:  if (scl_fall) state_nxt = rw ? RDATA : PTR;
        PTR:       if (scl_fall && byte_done) state_nxt = PTR_ACK;
        PTR_ACK:   if (scl_fall) state_nxt = WDATA;
        WDATA:     if (scl_fall && byte_done) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_nxt = WDATA;
        RDATA:     if (scl_fall && cnt == 3'd7) state_nxt = RACK;
        RACK: begin
          if (scl_rise && sda_s2)           state_nxt = WAIT;
          else if (scl_fall && byte_done)   state_nxt = RDATA;
        end
        default: ;
      endcase
    end
  end

  // SDA drive: only moves on SCL fall, released by START/STOP and never held in IDLE/WAIT
  always_comb begin
    oe_nxt = sda_oe_o;
    if (start || stop) oe_nxt = 1'b0;
    else if (scl_fall) begin
      case (state)
        ADDR, PTR, WDATA:   if (byte_done) oe_nxt = 1'b1;
        ADDR_ACK:           oe_nxt = rw ? ~regs[ptr][7] : 1'b0;
        RDATA:              oe_nxt = (cnt == 3'd7) ? 1'b0 : ~shreg[6];
        RACK:               oe_nxt = byte_done ? ~regs[ptr][7] : 1'b0;
        default:            oe_nxt = 1'b0;
      endcase
    end
    if (state_nxt == IDLE || state_nxt == WAIT) oe_nxt = 1'b0;
  end

  // Bit shifting, pointer and bus-side status
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      sda_oe_o  <= 1'b0;
      shreg     <= 7'h00;
      cnt       <= 3'd0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      ptr       <= 2'd0;
      busy      <= 1'b0;
    end else begin
      sda_oe_o <= oe_nxt;
      if (start) begin
        cnt       <= 3'd0;
        byte_done <= 1'b0;
      end else if (stop) begin
        cnt       <= 3'd0;
        byte_done <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg <= rx_byte[6:0];
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                // an unmatched address returns to IDLE, so no ACK is armed
                byte_done <= (state != ADDR) || match;
                if (state == ADDR)  rw  <= rx_byte[0];
                if (state == PTR)   ptr <= rx_byte[1:0];
                if (state == WDATA) ptr <= ptr + 2'd1;
              end
            end
            if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (state == ADDR) busy <= 1'b1;
            end
          end
          ADDR_ACK: begin
            if (scl_fall && rw) begin
              shreg <= regs[ptr][6:0];
              cnt   <= 3'd0;
            end
          end
          RDATA: begin
            if (scl_fall && cnt != 3'd7) begin
              cnt   <= cnt + 3'd1;
              shreg <= {shreg[5:0], 1'b0};
            end
          end
          RACK: begin
            if (scl_rise && !sda_s2) begin
              byte_done <= 1'b1;
              ptr       <= ptr + 2'd1;
            end
            if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              shreg     <= regs[ptr][6:0];
              cnt       <= 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file and local bus; the I2C write is applied last so it wins a same-cycle collision
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      wr_done <= 1'b0;
      d_out   <= 8'h00;
    end else begin
      if (cs && wr && addr[3:2] == 2'b00) regs[addr[1:0]] <= d_in[7:0];
      if (i2c_we) regs[ptr] <= rx_byte;
      if (cs && wr && addr == 4'd4 && d_in[1]) wr_done <= 1'b0;
      if (i2c_we) wr_done <= 1'b1;
      if (cs && rd) begin
        if (addr[3:2] == 2'b00) d_out <= regs[addr[1:0]];
        else if (addr == 4'd4)  d_out <= {6'b0, wr_done, busy};
        else                    d_out <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: local-bus vector table plus an I2C controller model on a wired-AND SDA.
// Latency: SCL quarter-phase of 100 ns (10 sys clocks) keeps SCL well below the sys_clk/8 limit.
// Backpressure: none modelled; the target never stretches SCL.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_low = 1'b0;
  logic        sda_oe;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [15:0] d_in = 16'h0000;
  logic [7:0]  d_out;
  wire         sda_bus;

  assign sda_bus = ~(sda_low | sda_oe);

  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(7'h50)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe_o(sda_oe),
    .cs(cs), .addr(addr), .rd(rd), .wr(wr), .d_in(d_in), .d_out(d_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Counts sys clocks where the target pulls SDA while a quiet window is being watched
  logic watch = 1'b0;
  int   oe_hits = 0;
  always @(negedge clk) if (watch && sda_oe) oe_hits++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; d_in = {8'h00, d};
    @(negedge clk); cs = 1'b0; wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  task automatic i2c_start;
    sda_low = 1'b0; #Q; scl = 1'b1; #Q; sda_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_low = 1'b1; #Q; scl = 1'b1; #Q; sda_low = 1'b0; #Q;
  endtask

  // Sends a byte and samples the target ACK; with collide set, the CPU writes 0x99 to
  // reg 2 on every sys clock up to and including the one where the LSB's SCL rise is seen.
  task automatic i2c_wr(input logic [7:0] b, input bit collide, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_low = ~b[i]; #Q; scl = 1'b1;
      if (collide && i == 0) begin
        cs = 1'b1; wr = 1'b1; addr = 4'd2; d_in = 16'h0099;
        repeat (3) @(posedge clk);
        #1; cs = 1'b0; wr = 1'b0;
        #(2*Q-26);
      end else begin
        #(2*Q);
      end
      scl = 1'b0; #Q;
    end
    sda_low = 1'b0; #Q; scl = 1'b1; #Q; ack = (sda_bus == 1'b0); #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_rd(input bit nack, output logic [7:0] b);
    sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b[i] = sda_bus; #Q; scl = 1'b0; #Q;
    end
    sda_low = ~nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  typedef struct {
    bit         is_wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t v(bit w, logic [3:0] a, logic [7:0] d, logic [7:0] e);
    vec_t r;
    r.is_wr = w; r.a = a; r.d = d; r.exp = e;
    return r;
  endfunction

  vec_t vt[16];

  initial begin
    logic [7:0] r, r1, r2, r3;
    bit a1, a2, a3, a4;
    int h;

    // reset state, then bus table: reset reads, preload, readback, unmapped addresses
    vt[0]  = v(0, 4'd0, 8'h00, 8'h00);
    vt[1]  = v(0, 4'd1, 8'h00, 8'h00);
    vt[2]  = v(0, 4'd2, 8'h00, 8'h00);
    vt[3]  = v(0, 4'd3, 8'h00, 8'h00);
    vt[4]  = v(0, 4'd4, 8'h00, 8'h00);
    vt[5]  = v(1, 4'd0, 8'h5A, 8'h00);
    vt[6]  = v(1, 4'd1, 8'hC3, 8'h00);
    vt[7]  = v(1, 4'd2, 8'h0F, 8'h00);
    vt[8]  = v(1, 4'd3, 8'hF0, 8'h00);
    vt[9]  = v(0, 4'd3, 8'h00, 8'hF0);
    vt[10] = v(0, 4'd1, 8'h00, 8'hC3);
    vt[11] = v(0, 4'd2, 8'h00, 8'h0F);
    vt[12] = v(1, 4'd7, 8'hEE, 8'h00);
    vt[13] = v(0, 4'd7, 8'h00, 8'h00);
    vt[14] = v(0, 4'd15, 8'h00, 8'h00);
    vt[15] = v(0, 4'd0, 8'h00, 8'h5A);

    #100;
    check("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
    rst = 1'b0;
    h = oe_hits; watch = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (vt[i].is_wr) cpu_wr(vt[i].a, vt[i].d);
      else begin
        cpu_rd(vt[i].a, r);
        check($sformatf("bus_vec%0d", i), r, vt[i].exp);
      end
    end
    repeat (3) @(negedge clk);
    check("dout_hold", d_out, 8'h5A);
    repeat (40) @(negedge clk);
    watch = 1'b0;
    check("idle_no_sda", {7'b0, oe_hits != h}, 8'h00);

    // write with pointer 3 wrapping to 0
    i2c_start;
    i2c_wr(8'hA0, 0, a1);
    i2c_wr(8'h03, 0, a2);
    cpu_rd(4'd4, r);
    check("busy_mid_write", r, 8'h01);
    i2c_wr(8'h11, 0, a3);
    i2c_wr(8'h22, 0, a4);
    i2c_stop;
    check("wr_acks", {4'b0, a1, a2, a3, a4}, 8'h0F);
    cpu_rd(4'd3, r); check("wr_reg3", r, 8'h11);
    cpu_rd(4'd0, r); check("wr_reg0_wrap", r, 8'h22);
    cpu_rd(4'd1, r); check("wr_reg1_untouched", r, 8'hC3);
    cpu_rd(4'd4, r); check("status_wr_done", r, 8'h02);
    cpu_wr(4'd4, 8'h02);
    cpu_rd(4'd4, r); check("status_cleared", r, 8'h00);

    // sequential read from ptr 1 with repeated START, NACK on the last byte
    cpu_wr(4'd0, 8'h5A); cpu_wr(4'd1, 8'hC3); cpu_wr(4'd2, 8'h0F); cpu_wr(4'd3, 8'hF0);
    i2c_start;
    i2c_wr(8'hA0, 0, a1);
    i2c_wr(8'h01, 0, a2);
    i2c_start;
    i2c_wr(8'hA1, 0, a3);
    i2c_rd(0, r1);
    i2c_rd(0, r2);
    i2c_rd(1, r3);
    check("rd_acks", {5'b0, a1, a2, a3}, 8'h07);
    check("rd_byte0", r1, 8'hC3);
    check("rd_byte1", r2, 8'h0F);
    check("rd_byte2", r3, 8'hF0);
    check("rd_release_after_nack", {7'b0, sda_oe}, 8'h00);
    #Q;
    check("rd_still_released", {7'b0, sda_oe}, 8'h00);
    i2c_stop;

    // address mismatch: target must stay silent and not touch registers
    h = oe_hits; watch = 1'b1;
    i2c_start;
    i2c_wr(8'hA2, 0, a1);
    i2c_wr(8'h00, 0, a2);
    cpu_rd(4'd4, r); check("mismatch_not_busy", r, 8'h00);
    i2c_wr(8'h77, 0, a3);
    i2c_stop;
    watch = 1'b0;
    check("mismatch_acks", {5'b0, a1, a2, a3}, 8'h00);
    check("mismatch_no_sda", {7'b0, oe_hits != h}, 8'h00);
    cpu_rd(4'd0, r); check("mismatch_reg0", r, 8'h5A);
    cpu_rd(4'd4, r); check("mismatch_status", r, 8'h00);

    // collision: CPU 0x99 and I2C 0x44 land on reg 2 in the same cycle
    i2c_start;
    i2c_wr(8'hA0, 0, a1);
    i2c_wr(8'h02, 0, a2);
    i2c_wr(8'h44, 1, a3);
    i2c_stop;
    check("coll_acks", {5'b0, a1, a2, a3}, 8'h07);
    cpu_rd(4'd2, r); check("coll_reg2", r, 8'h44);

    // reset while the target drives the MSB (0) of reg 2
    i2c_start;
    i2c_wr(8'hA0, 0, a1);
    i2c_wr(8'h02, 0, a2);
    i2c_start;
    i2c_wr(8'hA1, 0, a3);
    check("midrd_acks", {5'b0, a1, a2, a3}, 8'h07);
    check("midrd_driving_zero", {7'b0, sda_oe}, 8'h01);
    #3; rst = 1'b1;
    #1; check("async_rst_oe", {7'b0, sda_oe}, 8'h00);
    #96; rst = 1'b0;
    cpu_rd(4'd2, r); check("rst_clears_reg2", r, 8'h00);
    cpu_wr(4'd1, 8'hAB); cpu_wr(4'd2, 8'hCD); cpu_wr(4'd3, 8'hEF);
    i2c_start;
    i2c_wr(8'hA1, 0, a1);
    i2c_rd(1, r);
    i2c_stop;
    check("post_rst_ack", {7'b0, a1}, 8'h01);
    check("post_rst_read_ptr0", r, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) companion to the team's I2C controller peripheral; exposes a 4 x 8-bit register file to an external I2C bus.
- Same local-bus shape as the controller (cs/addr/rd/wr/d_in/d_out) so the CPU can preload and read back registers.
- Intended bench use: close the loop with the controller on one open-drain bus.
- Supports write with register pointer, sequential read, auto-increment and repeated START.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit I2C address the block responds to.

Ports:
- sys_clk_i  input  1  system clock; SCL must be ≥8x slower than this clock.
- sys_rst_i  input  1  reset, asynchronous, active-high.
- scl_i  input  1  I2C SCL, asynchronous. The target never stretches the clock.
- sda_i  input  1  I2C SDA as seen on the bus, asynchronous.
- sda_oe_o  output  1  1 = pull SDA low; 0 = release SDA. The wrapper builds the open-drain pad.
- cs  input  1  local-bus chip select.
- addr  input  4  local-bus address.
- rd  input  1  local-bus read strobe.
- wr  input  1  local-bus write strobe.
- d_in  input  16  local-bus write data; only bits [7:0] are used.
- d_out  output  8  local-bus read data, registered.

Behaviour:
- **Reset:** sys_rst_i is asynchronous, active-high and acts immediately, including mid-transfer. It sets:
  - regs[0..3]=8'h00, ptr=0
  - sda_oe_o=0, d_out=8'h00, status=0
  - state=IDLE
  - synchronizer flops=1
- **Input sync and edge detect:**
  - scl_i and sda_i each pass through a 2-flop synchronizer plus one history flop.
  - scl_rise and scl_fall are detected from synchronized SCL.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
- **START and STOP priority:**
  - START, including repeated START, takes priority in any state: bit counter cleared, sda_oe_o=0, go to ADDR.
  - STOP in any state: sda_oe_o=0, go to IDLE, busy=0.
- **Bit timing:**
  - Received bits are sampled on scl_rise, MSB first, using a 3-bit counter.
  - sda_oe_o changes only on scl_fall.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th scl_rise:
    - match = byte[7:1]==TARGET_ADDR; rw = byte[0].
    - match: on the next scl_fall drive ACK (sda_oe_o=1), set busy=1, go to ADDR_ACK.
    - no match: go to IDLE without ACK.
  - ADDR_ACK: at the scl_fall ending the ACK, release SDA.
    - rw=0: go to PTR.
    - rw=1: load shreg=regs[ptr], drive MSB (sda_oe_o = ~bit7), go to RDATA.
  - PTR: receive 8 bits, then ptr = byte[1:0] and ACK. Go to PTR_ACK, then WDATA.
  - WDATA / WDATA_ACK:
    - On the 8th scl_rise, regs[ptr] is written with the byte and ptr = ptr+1 mod 4 (3 wraps to 0).
    - wr_done is set, then ACK, then return to WDATA for the next byte.
  - RDATA: on each scl_fall drive the next bit. After the 8th bit's scl_fall, release SDA and go to RACK.
  - RACK: sample the controller's ACK on scl_rise.
    - ACK (SDA=0): ptr = ptr+1 mod 4; at the next scl_fall load regs[ptr], drive its MSB, go to RDATA.
    - NACK (SDA=1): keep SDA released and wait for STOP/START (state WAIT).
- **Local bus:**
  - Writes occur on a clock edge where cs & wr:
    - addr 0–3: regs[addr] = d_in[7:0].
    - addr 4: writing 1 to bit1 clears wr_done.
    - Other addresses are ignored.
  - Reads occur on a clock edge where cs & rd, with d_out valid one cycle later:
    - addr 0–3: regs[addr].
    - addr 4: {6'b0, wr_done, busy}.
    - Other addresses read 8'h00.
  - d_out holds its value when not reading.
  - Collision: I2C write and CPU write to the same register in the same cycle → the I2C value wins.
- **Safety:** sda_oe_o must never be 1 while state is IDLE or WAIT.

Test Plan:
- Reset / idle:
  - Stimulus: assert sys_rst_i for 100 ns, then release.
  - Required: sda_oe_o=0; CPU reads of addr 0–4 all return 8'h00; no SDA activity while the bus is idle.
- I2C write with wrap-around:
  - Stimulus: START, 0xA0, ptr 0x03, data 0x11, 0x22, STOP.
  - Required: ACK on all 4 bytes; regs[3]=0x11, regs[0]=0x22; status reads 0x02. Writing 0x02 to addr 4 → status reads 0x00.
- Sequential read with repeated START:
  - Stimulus: CPU preloads regs = {0x5A, 0xC3, 0x0F, 0xF0}. Then START, 0xA0, ptr 0x01, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP.
  - Required: bytes 0xC3, 0x0F, 0xF0 are returned; SDA is released after the NACK.
- Address mismatch:
  - Stimulus: START, 0xA2, ptr 0x00, data 0x77, STOP.
  - Required: no ACK (sda_oe_o stays 0 throughout); regs unchanged; busy never set.
- Collision:
  - Stimulus: CPU writes 0x99 to addr 2 in the same cycle as the I2C commit of 0x44 to reg 2.
  - Required: regs[2]=0x44.
- Reset mid-read:
  - Stimulus: assert sys_rst_i while the target is driving a 0 data bit.
  - Required: sda_oe_o=0 immediately (asynchronously); the next START+0xA1 read returns 0x00 from ptr=0.
